// File: rtl/ajuste_pkg.sv
// Shared definitions for the date-field adjuster: key codes, FSM states,
// cursor positions and the calendar day-limit rule.
package ajuste_pkg;

    localparam logic [7:0] KEY_UP    = 8'h73;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [1:0] CAMPO_DIA  = 2'd0;
    localparam logic [1:0] CAMPO_MES  = 2'd1;
    localparam logic [1:0] CAMPO_ANIO = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } fsm_t;

    // Years live in 2000..2099, so divisibility by 4 is the whole leap rule.
    function automatic logic [4:0] dias_en_mes(input logic [3:0] mes, input logic bisiesto);
        case (mes)
            4'd2:                      return bisiesto ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/dias_mes.sv
// Combinational day limit for a given month and leap flag.
module dias_mes
    import ajuste_pkg::*;
(
    input  logic [3:0] mes,
    input  logic       bisiesto,
    output logic [4:0] max_dia
);

    assign max_dia = dias_en_mes(mes, bisiesto);

endmodule

// File: rtl/contador_ajuste_fecha.sv
// Day/month/year editor driven by PS/2 key events while the main FSM is in
// the date-edit state; emits a one-cycle commit pulse when edits were made.
module contador_ajuste_fecha
    import ajuste_pkg::*;
#(
    parameter int unsigned YW       = 7,
    parameter int unsigned YEAR_MAX = 99,
    parameter logic [7:0]  ST_EDIT  = 8'h7D,
    parameter logic [1:0]  EN_EDIT  = 2'd1,
    parameter logic [7:0]  K_UP     = KEY_UP,
    parameter logic [7:0]  K_DOWN   = KEY_DOWN,
    parameter logic [7:0]  K_LEFT   = KEY_LEFT,
    parameter logic [7:0]  K_RIGHT  = KEY_RIGHT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    estado,
    input  logic [1:0]    en,
    input  logic [7:0]    Cambio,
    input  logic          got_data,
    input  logic          load,
    input  logic [4:0]    dia_in,
    input  logic [3:0]    mes_in,
    input  logic [YW-1:0] anio_in,
    output logic [4:0]    Dia,
    output logic [3:0]    Mes,
    output logic [YW-1:0] Anio,
    output logic [1:0]    campo,
    output logic          editando,
    output logic          actualizar
);

    localparam logic [YW-1:0] Y_MAX = YW'(YEAR_MAX);

    fsm_t          state_q, state_d;
    logic          got_data_q;
    logic          dirty_q, dirty_d;
    logic [4:0]    dia_q, dia_d;
    logic [3:0]    mes_q, mes_d;
    logic [YW-1:0] anio_q, anio_d;
    logic [1:0]    campo_q, campo_d;

    logic          activo, key_ev, ev, up, down;
    logic [4:0]    max_cur, max_nxt, dia_base, dia_clamp;
    logic [3:0]    mes_cand;
    logic [YW-1:0] anio_cand;

    assign activo = (en == EN_EDIT) && (estado == ST_EDIT);
    assign key_ev = got_data && !got_data_q;
    assign ev     = (state_q == S_EDIT) && activo && key_ev;
    assign up     = ev && (Cambio == K_UP);
    assign down   = ev && (Cambio == K_DOWN);

    dias_mes u_max_cur (.mes(mes_q),    .bisiesto(anio_q[1:0] == 2'b00),    .max_dia(max_cur));
    dias_mes u_max_nxt (.mes(mes_cand), .bisiesto(anio_cand[1:0] == 2'b00), .max_dia(max_nxt));

    // Candidate month/year come from either a sanitised preload or a month/year key.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        mes_cand  = mes_q;
        anio_cand = anio_q;
        dia_base  = dia_q;
        if (state_q == S_IDLE && load) begin
            mes_cand  = (mes_in == 4'd0 || mes_in > 4'd12) ? 4'd1 : mes_in;
            anio_cand = (anio_in > Y_MAX) ? Y_MAX : anio_in;
            dia_base  = (dia_in == 5'd0) ? 5'd1 : dia_in;
        end else if (campo_q == CAMPO_MES) begin
            if (up)        mes_cand = (mes_q >= 4'd12) ? 4'd1 : mes_q + 4'd1;
            else if (down) mes_cand = (mes_q <= 4'd1) ? 4'd12 : mes_q - 4'd1;
        end else if (campo_q == CAMPO_ANIO) begin
            if (up)        anio_cand = (anio_q >= Y_MAX) ? '0 : anio_q + YW'(1);
            else if (down) anio_cand = (anio_q == '0) ? Y_MAX : anio_q - YW'(1);
        end
    end

    assign dia_clamp = (dia_base > max_nxt) ? max_nxt : dia_base;

    always_comb begin
        dia_d   = dia_q;
        mes_d   = mes_q;
        anio_d  = anio_q;
        campo_d = campo_q;
        dirty_d = dirty_q;
        if (state_q == S_IDLE) begin
            if (activo) begin
                campo_d = CAMPO_DIA;
                dirty_d = 1'b0;
            end
            if (load) begin
                mes_d  = mes_cand;
                anio_d = anio_cand;
                dia_d  = dia_clamp;
            end
        end else if (ev) begin
            if (Cambio == K_RIGHT) begin
                campo_d = (campo_q == CAMPO_ANIO) ? CAMPO_DIA : campo_q + 2'd1;
            end else if (Cambio == K_LEFT) begin
                campo_d = (campo_q == CAMPO_DIA) ? CAMPO_ANIO : campo_q - 2'd1;
            end else if (up || down) begin
                dirty_d = 1'b1;
                if (campo_q == CAMPO_DIA) begin
                    if (up) dia_d = (dia_q >= max_cur) ? 5'd1 : dia_q + 5'd1;
                    else    dia_d = (dia_q <= 5'd1) ? max_cur : dia_q - 5'd1;
                end else begin
                    mes_d  = mes_cand;
                    anio_d = anio_cand;
                    dia_d  = dia_clamp;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (activo) state_d = S_EDIT;
            S_EDIT:   if (!activo) state_d = dirty_q ? S_COMMIT : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        editando   = (state_q == S_EDIT);
        actualizar = (state_q == S_COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            got_data_q <= 1'b0;
            dirty_q    <= 1'b0;
            dia_q      <= 5'd1;
            mes_q      <= 4'd1;
            anio_q     <= '0;
            campo_q    <= CAMPO_DIA;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            got_data_q <= got_data;
            dirty_q    <= dirty_d;
            dia_q      <= dia_d;
            mes_q      <= mes_d;
            anio_q     <= anio_d;
            campo_q    <= campo_d;
        end
    end

    assign Dia   = dia_q;
    assign Mes   = mes_q;
    assign Anio  = anio_q;
    assign campo = campo_q;

endmodule

// File: tb/tb_contador_ajuste_fecha.sv
// Bench for contador_ajuste_fecha: directed vector table, hand sequences and
// randomized traffic against a calendar-arithmetic reference model.
module tb_contador_ajuste_fecha;

    localparam int YW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    estado, Cambio;
    logic [1:0]    en;
    logic          got_data, load;
    logic [4:0]    dia_in;
    logic [3:0]    mes_in;
    logic [YW-1:0] anio_in;
    logic [4:0]    Dia;
    logic [3:0]    Mes;
    logic [YW-1:0] Anio;
    logic [1:0]    campo;
    logic          editando, actualizar;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    contador_ajuste_fecha dut (
        .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(Cambio),
        .got_data(got_data), .load(load), .dia_in(dia_in), .mes_in(mes_in),
        .anio_in(anio_in), .Dia(Dia), .Mes(Mes), .Anio(Anio), .campo(campo),
        .editando(editando), .actualizar(actualizar)
    );

    // Reference model: plain integers and modular calendar arithmetic.
    int mdays [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int m_d, m_m, m_y, m_c;
    bit m_edit, m_commit, m_dirty, m_gdq;

    function automatic int maxd(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        return mdays[m-1];
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_d = 1; m_m = 1; m_y = 0; m_c = 0;
        m_edit = 0; m_commit = 0; m_dirty = 0; m_gdq = 0;
    endtask

    task automatic model_step();
        bit act, evt;
        int delta;
        act   = (en == 2'd1) && (estado == 8'h7D);
        evt   = got_data && !m_gdq;
        m_gdq = got_data;
        if (m_commit) begin
            m_commit = 0;
        end else if (!m_edit) begin
            if (load) begin
                m_m = (mes_in >= 1 && mes_in <= 12) ? int'(mes_in) : 1;
                m_y = imin(int'(anio_in), 99);
                m_d = imin((dia_in == 0) ? 1 : int'(dia_in), maxd(m_m, m_y));
            end
            if (act) begin
                m_edit = 1; m_c = 0; m_dirty = 0;
            end
        end else if (!act) begin
            m_edit   = 0;
            m_commit = m_dirty;
        end else if (evt) begin
            if (Cambio == 8'h74) m_c = (m_c + 1) % 3;
            else if (Cambio == 8'h6B) m_c = (m_c + 2) % 3;
            else if (Cambio == 8'h73 || Cambio == 8'h72) begin
                delta   = (Cambio == 8'h73) ? 1 : -1;
                m_dirty = 1;
                if (m_c == 0) m_d = ((m_d - 1 + delta + maxd(m_m, m_y)) % maxd(m_m, m_y)) + 1;
                else begin
                    if (m_c == 1) m_m = ((m_m - 1 + delta + 12) % 12) + 1;
                    else          m_y = (m_y + delta + 100) % 100;
                    m_d = imin(m_d, maxd(m_m, m_y));
                end
            end
        end
    endtask

    function automatic logic [31:0] pack(int d, int m, int y, int c, bit ed, bit ac);
        return {12'd0, 5'(d), 4'(m), 7'(y), 2'(c), ed, ac};
    endfunction

    function automatic logic [31:0] obs();
        return pack(Dia, Mes, Anio, campo, editando, actualizar);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check("model", obs(), pack(m_d, m_m, m_y, m_c, m_edit, m_commit));
    endtask

    task automatic set_act(bit a);
        estado = a ? 8'h7D : 8'h10;
        en     = 2'd1;
    endtask

    task automatic press(logic [7:0] code);
        Cambio = code; got_data = 1'b1; tick();
        got_data = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; set_act(0); Cambio = 8'h00; got_data = 1'b0; load = 1'b0;
        dia_in = '0; mes_in = '0; anio_in = '0;
        model_reset();
        tick(); tick();
        check("reset", obs(), pack(1, 1, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          act;
        logic [7:0]  key;
        bit          gd;
        bit          ld;
        int          di, mi, ai;
        int          ed, em, ey, ec;
        bit          eedit, eact;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit act, logic [7:0] key, bit gd, bit ld, int di, int mi, int ai,
                                int ed, int em, int ey, int ec, bit eedit, bit eact);
        vec_t v;
        v.act = act; v.key = key; v.gd = gd; v.ld = ld; v.di = di; v.mi = mi; v.ai = ai;
        v.ed = ed; v.em = em; v.ey = ey; v.ec = ec; v.eedit = eedit; v.eact = eact;
        return v;
    endfunction

    initial begin
        logic [7:0] keys [5];
        bit act_r;

        // Directed table, applied from the reset state 1/1/0.
        tbl.push_back(mk(0, 8'h00, 0, 1, 31,  1,  23,  31, 1, 23, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,  31, 1, 23, 0, 1, 0));
        tbl.push_back(mk(1, 8'h74, 1, 0,  0,  0,   0,  31, 1, 23, 1, 1, 0));
        tbl.push_back(mk(1, 8'h74, 0, 0,  0,  0,   0,  31, 1, 23, 1, 1, 0));
        tbl.push_back(mk(1, 8'h73, 1, 0,  0,  0,   0,  28, 2, 23, 1, 1, 0));
        tbl.push_back(mk(1, 8'h73, 0, 0,  0,  0,   0,  28, 2, 23, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,  28, 2, 23, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,  28, 2, 23, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 31,  1,  24,  31, 1, 24, 1, 0, 0));
        tbl.push_back(mk(1, 8'h74, 1, 0,  0,  0,   0,  31, 1, 24, 0, 1, 0));
        tbl.push_back(mk(1, 8'h74, 0, 0,  0,  0,   0,  31, 1, 24, 0, 1, 0));
        tbl.push_back(mk(1, 8'h74, 1, 0,  0,  0,   0,  31, 1, 24, 1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,  31, 1, 24, 1, 1, 0));
        tbl.push_back(mk(1, 8'h73, 1, 0,  0,  0,   0,  29, 2, 24, 1, 1, 0));
        tbl.push_back(mk(1, 8'h73, 0, 0,  0,  0,   0,  29, 2, 24, 1, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 1, 0,  0,  0,   0,  29, 2, 24, 0, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 0, 0,  0,  0,   0,  29, 2, 24, 0, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 1, 0,  0,  0,   0,  29, 2, 24, 2, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 0, 0,  0,  0,   0,  29, 2, 24, 2, 1, 0));
        tbl.push_back(mk(1, 8'h73, 1, 0,  0,  0,   0,  28, 2, 25, 2, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1,  0, 15, 120,  28, 2, 25, 2, 1, 0));
        tbl.push_back(mk(0, 8'h73, 1, 0,  0,  0,   0,  28, 2, 25, 2, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1,  0, 15, 120,  28, 2, 25, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1,  0, 15, 120,   1, 1, 99, 2, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 0, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 1, 0,  0,  0,   0,   1, 1, 99, 2, 1, 0));
        tbl.push_back(mk(1, 8'h6B, 0, 0,  0,  0,   0,   1, 1, 99, 2, 1, 0));
        tbl.push_back(mk(1, 8'h73, 1, 0,  0,  0,   0,   1, 1,  0, 2, 1, 0));
        tbl.push_back(mk(1, 8'h73, 0, 0,  0,  0,   0,   1, 1,  0, 2, 1, 0));
        tbl.push_back(mk(1, 8'h72, 1, 0,  0,  0,   0,   1, 1, 99, 2, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 2, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 2, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 2, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 0, 1, 0));
        tbl.push_back(mk(1, 8'h74, 1, 0,  0,  0,   0,   1, 1, 99, 1, 1, 0));
        tbl.push_back(mk(1, 8'h74, 0, 0,  0,  0,   0,   1, 1, 99, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0,  0,  0,   0,   1, 1, 99, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 31,  2,  23,  28, 2, 23, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 30,  4,   5,  30, 4,  5, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 31,  4,   5,  30, 4,  5, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 30,  2,  24,  29, 2, 24, 0, 0, 0));

        // Sequence A: day wraps 1..31..1, then a commit pulse on exit.
        do_reset();
        set_act(1); tick();
        check("enter_edit", {31'd0, editando}, 32'd1);
        for (int k = 1; k <= 31; k++) begin
            press(8'h73);
            check($sformatf("day_up%0d", k), {27'd0, Dia}, 32'((k % 31) + 1));
        end
        set_act(0); tick();
        check("commit_pulse", {30'd0, editando, actualizar}, 32'b01);
        tick();
        check("commit_end", {30'd0, editando, actualizar}, 32'b00);

        // Vector table.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            set_act(tbl[i].act);
            Cambio   = tbl[i].key;
            got_data = tbl[i].gd;
            load     = tbl[i].ld;
            dia_in   = 5'(tbl[i].di);
            mes_in   = 4'(tbl[i].mi);
            anio_in  = YW'(tbl[i].ai);
            tick();
            check($sformatf("vec%0d", i), obs(),
                  pack(tbl[i].ed, tbl[i].em, tbl[i].ey, tbl[i].ec, tbl[i].eedit, tbl[i].eact));
        end
        load = 1'b0; got_data = 1'b0;

        // Sequence B: got_data held for 10 cycles gives a single decrement.
        set_act(0); tick(); tick();
        load = 1'b1; dia_in = 5'd5; mes_in = 4'd1; anio_in = 7'd10; tick();
        load = 1'b0;
        set_act(1); tick();
        press(8'h74);
        Cambio = 8'h72; got_data = 1'b1;
        repeat (10) tick();
        check("hold_down_mes", {28'd0, Mes}, 32'd12);
        got_data = 1'b0; tick();
        check("hold_down_date", obs(), pack(5, 12, 10, 1, 1, 0));

        // Sequence C: asynchronous reset mid-edit, no commit afterwards.
        press(8'h73);
        #3 rst = 1'b1;
        #1 check("rst_async", obs(), pack(1, 1, 0, 0, 0, 0));
        model_reset();
        set_act(0); got_data = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_no_pulse%0d", k), {31'd0, actualizar}, 32'd0);
        end

        // Randomized traffic against the model.
        keys[0] = 8'h73; keys[1] = 8'h72; keys[2] = 8'h6B; keys[3] = 8'h74; keys[4] = 8'h00;
        act_r = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 6) act_r = !act_r;
            if (act_r) set_act(1);
            else if ($urandom_range(0, 1) == 1) begin
                estado = 8'($urandom_range(0, 124)); en = 2'd1;
            end else begin
                estado = 8'h7D; en = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'd2;
            end
            keys[4] = 8'($urandom);
            Cambio  = keys[$urandom_range(0, 4)];
            if ($urandom_range(0, 99) < 40) got_data = !got_data;
            load    = ($urandom_range(0, 99) < 10);
            dia_in  = 5'($urandom_range(0, 31));
            mes_in  = 4'($urandom_range(0, 15));
            anio_in = 7'($urandom_range(0, 127));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_ajuste_fecha.md
# contador_ajuste_fecha

Parametrised date-field adjuster: successor to the single-field month counter. Holds day, month and year registers edited from PS/2 scan codes while the FSM sits in the date-edit state. Adds a field cursor, calendar-correct day limits (leap years included), preload from the RTC readback path, and a commit pulse for the RTC write sequencer.

## Interface
- `YW`, 7: year field width.
- `YEAR_MAX`, 99: largest year value (years 2000+0..YEAR_MAX).
- `ST_EDIT`, 8'h7D: `estado` value that enables editing.
- `EN_EDIT`, 2'd1: `en` value that enables editing.
- `K_UP`, 8'h73: increment key code.
- `K_DOWN`, 8'h72: decrement key code.
- `K_LEFT`, 8'h6B: move cursor left.
- `K_RIGHT`, 8'h74: move cursor right.

- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `estado` in 8: main FSM state code.
- `en` in 2: adjust-mode select.
- `Cambio` in 8: last PS/2 scan code.
- `got_data` in 1: scan-code valid, level; may stay high for several cycles.
- `load` in 1: copy `dia_in`/`mes_in`/`anio_in` into the fields.
- `dia_in` in 5, `mes_in` in 4, `anio_in` in YW: preload values from the RTC.
- `Dia` out 5, `Mes` out 4, `Anio` out YW: current field values, binary.
- `campo` out 2: cursor position (0 = day, 1 = month, 2 = year).
- `editando` out 1: high while in EDIT.
- `actualizar` out 1: one-cycle commit pulse.

## Operation
- `activo = (en == EN_EDIT) && (estado == ST_EDIT)`.
- FSM states:
  - IDLE: `editando`=0.
  - EDIT: `editando`=1.
  - COMMIT: one cycle, `actualizar`=1.
- FSM transitions:
  - IDLE→EDIT when `activo`. On entry, `campo`←0 and `dirty`←0.
  - EDIT→COMMIT when `!activo` and `dirty`.
  - EDIT→IDLE when `!activo` and `!dirty`.
  - COMMIT→IDLE unconditionally.
- Key strobe: `got_data` is registered. A key event is `got_data && !got_data_q`, so one event per assertion.
- Events act only in EDIT with `activo` high. Any other scan code is ignored.
- `K_RIGHT`: `campo` 0→1→2→0. `K_LEFT`: `campo` 0→2→1→0.
- `K_UP`/`K_DOWN` act on the selected field and set `dirty`.
  - Day: up wraps max→1; down wraps 1→max.
  - Month: up wraps 12→1; down wraps 1→12.
  - Year: up wraps YEAR_MAX→0; down wraps 0→YEAR_MAX.
- Day max (`dias_mes`):
  - Month 2: 29 if `Anio[1:0]==0`, else 28.
  - Months 4, 6, 9, 11: 30.
  - Otherwise: 31.
- Clamp: if a month or year change makes `Dia` exceed the new max, `Dia`←new max on the same edge. Example: 31/Jan, month up → 29/Feb (leap) or 28/Feb.
- `load` is honoured in IDLE only and ignored in EDIT/COMMIT. Sanitising on load:
  - Month 0 or >12 → 1.
  - Year > YEAR_MAX → YEAR_MAX.
  - Day 0 → 1.
  - Day > max → max, computed from the sanitised month/year.
- Invariant: fields are never outside their legal range.

## Timing
- Reset values: `Dia`=1, `Mes`=1, `Anio`=0, `campo`=0, `editando`=0, `actualizar`=0, state IDLE, `got_data_q`=0, `dirty`=0.
- Key event latency: field/cursor update is visible one cycle after the edge where `got_data` is first sampled high.
- `activo` rising: `editando` is high after the next edge. A key event sampled on that same edge is ignored.
- `activo` falling with `dirty` set: `actualizar` is high for exactly one cycle, beginning after the next edge. Fields are stable during and after the pulse.
- Simultaneous `activo` drop and key event: the key is ignored.
- `load` and edit do not conflict: load is IDLE-only.
- Reset mid-edit: immediate return to reset values; no `actualizar` pulse.

## Structure
- Package `ajuste_pkg`:
  - Key-code constants.
  - State enum.
  - Field index constants.
  - Function `dias_en_mes(mes, bisiesto)`.
- Sub-module `dias_mes`: combinational, `mes`[3:0] + `bisiesto` → `max_dia`[4:0]. Instantiated twice: current values and candidate/next values for clamping.
- RTL target: ~200 lines.

## Test plan
- Reset, then activate, `campo`=0, `K_UP`×31 → `Dia` 1→31→1. Drop `activo` → one `actualizar` pulse, `editando`=0.
- Preload 31/01/Anio=23 in IDLE, edit month `K_UP` → `Mes`=2, `Dia`=28. Same with Anio=24 → `Dia`=29.
- `got_data` held high 10 cycles with `K_DOWN` on month=1 → single decrement, `Mes`=12.
- `K_LEFT` from `campo`=0 → 2. Year `K_DOWN` at 0 → 99. At 29/02/Anio=24, year `K_UP` → `Dia`=28.
- `load` with `dia_in`=0, `mes_in`=15, `anio_in`=120 → 1/1/99. `load` during EDIT → no change.
- Enter/leave EDIT with no key, or cursor moves only → no `actualizar`. `rst` asserted mid-edit → fields 1/1/0 asynchronously, no pulse.
